// File: rtl/alu_muldiv_seq.sv
// ---------------------------------------------------------------------------
// alu_muldiv_seq
//
// Multi-cycle sequencer for a 16x16 unsigned multiply and a 16/16 unsigned
// restoring divide. It does no arithmetic of its own. In every RUN cycle it
// drives the operands and opcode of the shared external ALU, then captures
// the ALU result and ZCNV flags on the same clock edge.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | waiting for start; results and CCout hold the last operation
// RUN   | one shift/add (mul) or shift/subtract (div) iteration per cycle
// DONE  | done pulse; CCout and divZero reflect the finished operation
//
// Ports:
//   clock, reset_L   rising-edge clock, asynchronous active-low reset
//   start, op        start request (sampled in IDLE), 0 = mul, 1 = div
//   srcA, srcB       multiplicand/dividend, multiplier/divisor
//   busy, done       high throughout RUN / one-cycle pulse in DONE
//   resultHi/Lo      product[31:16]/remainder, product[15:0]/quotient
//   CCout, divZero   {Z,C,N,V} of the final result, divide-by-zero flag
//   aluA/aluB/aluOp  drive to the external ALU (zero outside RUN)
//   aluOut, aluCC    combinational result and {Z,C,N,V} from the ALU
// ---------------------------------------------------------------------------
module alu_muldiv_seq #(
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset_L,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] srcA,
    input  logic [WIDTH-1:0] srcB,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] resultHi,
    output logic [WIDTH-1:0] resultLo,
    output logic [3:0]       CCout,
    output logic             divZero,
    output logic [WIDTH-1:0] aluA,
    output logic [WIDTH-1:0] aluB,
    output logic [3:0]       aluOp,
    input  logic [WIDTH-1:0] aluOut,
    input  logic [3:0]       aluCC
);

    localparam int CW = $clog2(WIDTH);

    localparam logic [3:0] OP_PASS = 4'b0000;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0101;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    // hi_reg is P (mul) or R (div); lo_reg is Q; m_reg is M (mul) or D (div)
    logic [WIDTH-1:0] hi_reg;
    logic [WIDTH-1:0] lo_reg;
    logic [WIDTH-1:0] m_reg;
    logic [CW-1:0]    cnt;
    logic             op_reg;
    logic             dz_cur;
    logic [3:0]       cc_reg;
    logic             dz_reg;

    logic [WIDTH-1:0] sh;
    logic             ovf;
    logic             ge;
    logic [3:0]       cc_now;

    // Only Z and C are consumed from the ALU flags.
    logic unused_cc;
    assign unused_cc = &{1'b0, aluCC[1:0]};

    // Divide: shift the next dividend bit into the partial remainder. If the
    // bit shifted out of R was set, sh is really 17 bits and always >= D.
    assign sh  = {hi_reg[WIDTH-2:0], lo_reg[WIDTH-1]};
    assign ovf = hi_reg[WIDTH-1];
    // ALU C on subtract means A <= B, so A >= B is "no C, or equal (Z)".
    assign ge  = ovf | ~aluCC[2] | aluCC[3];

    always_comb begin
        cc_now = 4'b0000;
        if (op_reg) begin
            cc_now = {(lo_reg == '0), 1'b0, lo_reg[WIDTH-1], dz_cur};
        end else begin
            cc_now = {((hi_reg == '0) && (lo_reg == '0)), (hi_reg != '0),
                      hi_reg[WIDTH-1], 1'b0};
        end
    end

    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        aluA      = '0;
        aluB      = '0;
        aluOp     = OP_PASS;
        case (state)
            S_IDLE: begin
                if (start) begin
                    if (op && (srcB == '0)) begin
                        state_nxt = S_DONE;
                    end else begin
                        state_nxt = S_RUN;
                    end
                end
            end
            S_RUN: begin
                busy = 1'b1;
                if (op_reg) begin
                    aluA  = sh;
                    aluB  = m_reg;
                    aluOp = OP_SUB;
                end else begin
                    aluA  = hi_reg;
                    aluB  = m_reg;
                    aluOp = lo_reg[0] ? OP_ADD : OP_PASS;
                end
                if (cnt == '0) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            hi_reg <= '0;
            lo_reg <= '0;
            m_reg  <= '0;
            cnt    <= '0;
            op_reg <= 1'b0;
            dz_cur <= 1'b0;
            cc_reg <= 4'b0000;
            dz_reg <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        op_reg <= op;
                        cnt    <= CW'(WIDTH - 1);
                        m_reg  <= op ? srcB : srcA;
                        if (op && (srcB == '0)) begin
                            hi_reg <= srcA;
                            lo_reg <= '1;
                            dz_cur <= 1'b1;
                        end else begin
                            hi_reg <= '0;
                            lo_reg <= op ? srcA : srcB;
                            dz_cur <= 1'b0;
                        end
                    end
                end
                S_RUN: begin
                    cnt <= cnt - 1'b1;
                    if (op_reg) begin
                        // 16-bit wrap of aluOut is exact when ovf is set.
                        hi_reg <= ge ? aluOut : sh;
                        lo_reg <= {lo_reg[WIDTH-2:0], ge};
                    end else begin
                        // Carry out of the add becomes the new top bit of P.
                        hi_reg <= {aluCC[2], aluOut[WIDTH-1:1]};
                        lo_reg <= {aluOut[0], lo_reg[WIDTH-1:1]};
                    end
                end
                S_DONE: begin
                    cc_reg <= cc_now;
                    dz_reg <= dz_cur;
                end
                default: ;
            endcase
        end
    end

    assign resultHi = hi_reg;
    assign resultLo = lo_reg;
    // Flags become visible in the DONE cycle itself and are then held.
    assign CCout    = (state == S_DONE) ? cc_now : cc_reg;
    assign divZero  = (state == S_DONE) ? dz_cur : dz_reg;

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// ---------------------------------------------------------------------------
// tb_alu_muldiv_seq
//
// Bench for alu_muldiv_seq. Contains a behavioural model of the external
// WileE240 ALU (pass, add, subtract) and a reference model that computes
// products, quotients and remainders with plain arithmetic.
// ---------------------------------------------------------------------------
module tb_alu_muldiv_seq;

    logic        clock;
    logic        reset_L;
    logic        start;
    logic        op;
    logic [15:0] srcA;
    logic [15:0] srcB;
    logic        busy;
    logic        done;
    logic [15:0] resultHi;
    logic [15:0] resultLo;
    logic [3:0]  CCout;
    logic        divZero;
    logic [15:0] aluA;
    logic [15:0] aluB;
    logic [3:0]  aluOp;
    logic [15:0] aluOut;
    logic [3:0]  aluCC;

    int checks   = 0;
    int failures = 0;
    logic cur_op = 1'b0;

    alu_muldiv_seq #(.WIDTH(16)) dut (
        .clock    (clock),
        .reset_L  (reset_L),
        .start    (start),
        .op       (op),
        .srcA     (srcA),
        .srcB     (srcB),
        .busy     (busy),
        .done     (done),
        .resultHi (resultHi),
        .resultLo (resultLo),
        .CCout    (CCout),
        .divZero  (divZero),
        .aluA     (aluA),
        .aluB     (aluB),
        .aluOp    (aluOp),
        .aluOut   (aluOut),
        .aluCC    (aluCC)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // External ALU model
    logic [16:0] alu_wide;
    logic [15:0] alu_res;
    logic        alu_c;
    logic        alu_v;
    always_comb begin
        alu_wide = 17'd0;
        alu_res  = 16'd0;
        alu_c    = 1'b0;
        alu_v    = 1'b0;
        case (aluOp)
            4'b0000: alu_res = aluA;
            4'b0010: begin
                alu_wide = {1'b0, aluA} + {1'b0, aluB};
                alu_res  = alu_wide[15:0];
                alu_c    = alu_wide[16];
                alu_v    = (aluA[15] == aluB[15]) && (alu_res[15] != aluA[15]);
            end
            4'b0101: begin
                alu_res = aluA - aluB;
                alu_c   = (aluA <= aluB);
                alu_v   = (aluA[15] != aluB[15]) && (alu_res[15] != aluA[15]);
            end
            default: alu_res = 16'd0;
        endcase
        aluOut = alu_res;
        aluCC  = {(alu_res == 16'd0), alu_c, alu_res[15], alu_v};
    end

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ALU drive legality, every cycle outside reset
    always @(negedge clock) begin
        if (reset_L) begin
            checks++;
            if (busy) begin
                if (cur_op ? (aluOp != 4'b0101) : !(aluOp == 4'b0000 || aluOp == 4'b0010)) begin
                    failures++;
                    $display("FAIL alu_op_busy: got %b for op %0d", aluOp, cur_op);
                end
            end else if (aluOp != 4'b0000 || aluA != 16'd0 || aluB != 16'd0) begin
                failures++;
                $display("FAIL alu_idle_drive: got op=%b a=%h b=%h expected zeros", aluOp, aluA, aluB);
            end
        end
    end

    task automatic ref_model(input logic o, input logic [15:0] a, input logic [15:0] b,
                             output logic [15:0] hi, output logic [15:0] lo,
                             output logic [3:0] cc, output logic dz, output int lat);
        logic [31:0] prod;
        if (!o) begin
            prod = {16'd0, a} * {16'd0, b};
            hi = prod[31:16];
            lo = prod[15:0];
            dz = 1'b0;
            cc = {(prod == 32'd0), (hi != 16'd0), hi[15], 1'b0};
            lat = 17;
        end else if (b == 16'd0) begin
            hi = a;
            lo = 16'hFFFF;
            dz = 1'b1;
            cc = 4'b0011;
            lat = 1;
        end else begin
            hi = a % b;
            lo = a / b;
            dz = 1'b0;
            cc = {(lo == 16'd0), 1'b0, lo[15], 1'b0};
            lat = 17;
        end
    endtask

    task automatic run_op(input logic o, input logic [15:0] a, input logic [15:0] b,
                          output int lat, output int bc);
        @(negedge clock);
        start  = 1'b1;
        op     = o;
        srcA   = a;
        srcB   = b;
        cur_op = o;
        lat = 0;
        bc  = 0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clock);
            start = 1'b0;
            if (busy) bc++;
            if (done) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic run_and_check(input string tag, input logic o, input logic [15:0] a,
                                 input logic [15:0] b, input logic [15:0] ehi,
                                 input logic [15:0] elo, input logic [3:0] ecc,
                                 input logic edz, input int elat);
        int lat, bc;
        run_op(o, a, b, lat, bc);
        check({tag, " latency"}, 80'(lat), 80'(elat));
        check({tag, " busy_cycles"}, 80'(bc), 80'(elat == 1 ? 0 : 16));
        check({tag, " resultHi"}, 80'(resultHi), 80'(ehi));
        check({tag, " resultLo"}, 80'(resultLo), 80'(elo));
        check({tag, " CCout"}, 80'(CCout), 80'(ecc));
        check({tag, " divZero"}, 80'(divZero), 80'(edz));
    endtask

    typedef struct {
        logic        o;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] hi;
        logic [15:0] lo;
        logic [3:0]  cc;
        logic        dz;
        int          lat;
    } vec_t;

    vec_t vecs[6];

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] ehi, elo;
        logic [3:0]  ecc;
        logic        edz;
        int          elat, lat, bc, dcnt;
        logic        ro;
        logic [15:0] ra, rb;

        vecs[0] = '{1'b0, 16'h0003, 16'h0005, 16'h0000, 16'h000F, 4'b0000, 1'b0, 17};
        vecs[1] = '{1'b0, 16'hFFFF, 16'hFFFF, 16'hFFFE, 16'h0001, 4'b0110, 1'b0, 17};
        vecs[2] = '{1'b1, 16'd100,  16'd7,    16'h0002, 16'h000E, 4'b0000, 1'b0, 17};
        vecs[3] = '{1'b1, 16'hFFFF, 16'h8000, 16'h7FFF, 16'h0001, 4'b0000, 1'b0, 17};
        vecs[4] = '{1'b1, 16'h1234, 16'h0000, 16'h1234, 16'hFFFF, 4'b0011, 1'b1, 1};
        vecs[5] = '{1'b0, 16'h0000, 16'h1234, 16'h0000, 16'h0000, 4'b1000, 1'b0, 17};

        reset_L = 1'b0;
        start   = 1'b0;
        op      = 1'b0;
        srcA    = 16'd0;
        srcB    = 16'd0;
        repeat (2) @(negedge clock);
        check("reset_outputs",
              80'({busy, done, resultHi, resultLo, CCout, divZero, aluA, aluB, aluOp}), 80'd0);
        reset_L = 1'b1;

        for (int i = 0; i < 6; i++) begin
            run_and_check($sformatf("vec%0d", i), vecs[i].o, vecs[i].a, vecs[i].b,
                          vecs[i].hi, vecs[i].lo, vecs[i].cc, vecs[i].dz, vecs[i].lat);
        end

        // Divide after divide-by-zero clears the flag (vec5 was a multiply;
        // repeat the dz case then a normal divide directly after it).
        run_and_check("dz_again", 1'b1, 16'h00AA, 16'h0000, 16'h00AA, 16'hFFFF, 4'b0011, 1'b1, 1);
        run_and_check("dz_clear", 1'b1, 16'd50, 16'd5, 16'd0, 16'd10, 4'b0000, 1'b0, 17);

        for (int i = 0; i < 30; i++) begin
            ro = 1'($urandom_range(0, 1));
            ra = 16'($urandom);
            rb = ($urandom_range(0, 5) == 0) ? 16'd0 : 16'($urandom);
            if ($urandom_range(0, 3) == 0) rb = 16'($urandom_range(1, 15));
            ref_model(ro, ra, rb, ehi, elo, ecc, edz, elat);
            run_and_check($sformatf("rand%0d", i), ro, ra, rb, ehi, elo, ecc, edz, elat);
        end

        // Start during RUN is ignored; result holds afterwards.
        @(negedge clock);
        start = 1'b1; op = 1'b0; srcA = 16'h0003; srcB = 16'h0005; cur_op = 1'b0;
        @(negedge clock);
        start = 1'b0;
        repeat (4) @(negedge clock);
        start = 1'b1; op = 1'b1; srcA = 16'h0999; srcB = 16'h0009;
        @(negedge clock);
        start = 1'b0;
        lat = 0;
        for (int n = 7; n <= 40; n++) begin
            @(negedge clock);
            if (done) begin
                lat = n;
                break;
            end
        end
        check("ignored_start latency", 80'(lat), 80'd17);
        check("ignored_start result", 80'({resultHi, resultLo, CCout}), 80'({16'h0000, 16'h000F, 4'b0000}));
        repeat (3) @(negedge clock);
        check("hold_after_done", 80'({busy, done, resultHi, resultLo, CCout}),
              80'({1'b0, 1'b0, 16'h0000, 16'h000F, 4'b0000}));

        // Reset in the middle of RUN abandons the operation.
        @(negedge clock);
        start = 1'b1; op = 1'b0; srcA = 16'hFFFF; srcB = 16'hFFFF; cur_op = 1'b0;
        @(negedge clock);
        start = 1'b0;
        repeat (7) @(negedge clock);
        check("busy_before_reset", 80'(busy), 80'd1);
        reset_L = 1'b0;
        #1;
        check("midrun_reset_outputs",
              80'({busy, done, resultHi, resultLo, CCout, divZero, aluA, aluB, aluOp}), 80'd0);
        @(negedge clock);
        reset_L = 1'b1;
        dcnt = 0;
        for (int n = 0; n < 25; n++) begin
            @(negedge clock);
            if (done) dcnt++;
        end
        check("no_done_after_reset", 80'(dcnt), 80'd0);
        run_and_check("after_reset", 1'b1, 16'd100, 16'd7, 16'h0002, 16'h000E, 4'b0000, 1'b0, 17);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
